// File: rtl/level_sequencer_pkg.sv
// Shared types and default sizing for the level sequencer.
// State encoding is fixed so waveforms read the same across builds.
package level_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_MOVE  = 2'b01,
    S_DWELL = 2'b10,
    S_DONE  = 2'b11
  } seq_state_t;

  localparam int DEF_LEVEL_W = 2;
  localparam int DEF_DWELL_W = 4;

endpackage

// File: rtl/level_sequencer_if.sv
// Request/status bundle between a requester (master) and the sequencer (slave).
interface level_sequencer_if #(
  parameter int LEVEL_W = 2,
  parameter int DWELL_W = 4
);
  logic               req_valid;
  logic               req_ready;
  logic [LEVEL_W-1:0] req_level;
  logic [DWELL_W-1:0] req_dwell;
  logic               abort;
  logic [LEVEL_W-1:0] level;
  logic               step_up;
  logic               step_dn;
  logic               busy;
  logic               done;

  modport master (
    output req_valid, req_level, req_dwell, abort,
    input  req_ready, level, step_up, step_dn, busy, done
  );

  modport slave (
    input  req_valid, req_level, req_dwell, abort,
    output req_ready, level, step_up, step_dn, busy, done
  );
endinterface

// File: rtl/level_sequencer_dwell_timer.sv
// Loadable down-counter that times the idle gap between level steps.
// Counts down while enabled and parks at zero.
module dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/level_sequencer.sv
// Walks a saturating level one step at a time toward a requested target,
// with a programmable dwell between steps and a one-cycle done pulse.
module level_sequencer
  import level_seq_pkg::*;
#(
  parameter int LEVEL_W = DEF_LEVEL_W,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input logic               clk,
  input logic               reset_n,
  level_sequencer_if.slave  bus
);
  seq_state_t         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] target_q, target_d;
  logic [DWELL_W-1:0] dwell_cfg_q, dwell_cfg_d;

  logic               tmr_load;
  logic               tmr_en;
  logic               tmr_zero;
  logic [DWELL_W-1:0] tmr_val;
  logic               go_up;
  logic               go_dn;
  logic               in_move;

  assign go_up   = (target_q > level_q);
  assign go_dn   = (target_q < level_q);
  assign in_move = (state_q == S_MOVE);
  assign tmr_val = dwell_cfg_q - DWELL_W'(1);

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    target_d    = target_q;
    dwell_cfg_d = dwell_cfg_q;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          target_d    = bus.req_level;
          dwell_cfg_d = bus.req_dwell;
          state_d     = (bus.req_level == level_q) ? S_DONE : S_MOVE;
        end
      end
      S_MOVE: begin
        // Abort suppresses the step entirely: level holds, no done pulse.
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          level_d = go_up ? level_q + LEVEL_W'(1) : level_q - LEVEL_W'(1);
          if (level_d == target_q) begin
            state_d = S_DONE;
          end else if (dwell_cfg_q != '0) begin
            state_d  = S_DWELL;
            tmr_load = 1'b1;
          end else begin
            state_d = S_MOVE;
          end
        end
      end
      S_DWELL: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (tmr_zero) begin
          state_d = S_MOVE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      level_q     <= '0;
      target_q    <= '0;
      dwell_cfg_q <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      target_q    <= target_d;
      dwell_cfg_q <= dwell_cfg_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.level     = level_q;
  assign bus.step_up   = in_move && go_up && !bus.abort;
  assign bus.step_dn   = in_move && go_dn && !bus.abort;
  assign bus.busy      = (state_q == S_MOVE) || (state_q == S_DWELL);
  assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_level_sequencer.sv
// Directed plus randomized bench for level_sequencer; expected cycle-by-cycle
// behaviour is derived from the step/dwell schedule arithmetic.
module tb_level_sequencer;
  localparam int LW = 2;
  localparam int DW = 4;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   model_level = 0;

  level_sequencer_if #(.LEVEL_W(LW), .DWELL_W(DW)) bus ();

  level_sequencer #(.LEVEL_W(LW), .DWELL_W(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int lvl, input int su, input int sd,
                          input int bz, input int dn, input int rd);
    chk({tag, ".level"},   32'(bus.level),     32'(lvl));
    chk({tag, ".step_up"}, 32'(bus.step_up),   32'(su));
    chk({tag, ".step_dn"}, 32'(bus.step_dn),   32'(sd));
    chk({tag, ".busy"},    32'(bus.busy),      32'(bz));
    chk({tag, ".done"},    32'(bus.done),      32'(dn));
    chk({tag, ".ready"},   32'(bus.req_ready), 32'(rd));
  endtask

  // Issue one request and check every cycle until req_ready returns.
  // ja >= 0 asserts abort during that cycle offset (only meaningful while busy).
  task automatic run_req(input string tag, input int t, input int dw, input int ja);
    int l0, d, dir, ne, j, lvl, held;
    bit fin;
    l0  = model_level;
    d   = (t > l0) ? t - l0 : l0 - t;
    dir = (t > l0) ? 1 : -1;
    ne  = (d == 0) ? 0 : 1 + (d - 1) * (dw + 1);
    @(negedge clk);
    chk({tag, ".pre_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_level = LW'(t);
    bus.req_dwell = DW'(dw);
    j   = 0;
    fin = 1'b0;
    while (!fin && j < 200) begin
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.abort     = (ja >= 0 && j == ja);
      @(negedge clk);
      if (d == 0) begin
        if (j == 0) chk_outs(tag, l0, 0, 0, 0, 1, 0);
        else begin
          chk_outs(tag, l0, 0, 0, 0, 0, 1);
          fin = 1'b1;
        end
      end else if (ja >= 0 && ja < ne) begin
        held = l0 + dir * ((ja + dw) / (dw + 1));
        if (j <= ja) begin
          lvl = l0 + dir * ((j + dw) / (dw + 1));
          chk_outs(tag, lvl, (dir > 0 && j % (dw + 1) == 0 && j != ja) ? 1 : 0,
                   (dir < 0 && j % (dw + 1) == 0 && j != ja) ? 1 : 0, 1, 0, 0);
        end else begin
          chk_outs(tag, held, 0, 0, 0, 0, 1);
          model_level = held;
          fin = 1'b1;
        end
      end else begin
        if (j < ne) begin
          lvl = l0 + dir * ((j + dw) / (dw + 1));
          chk_outs(tag, lvl, (dir > 0 && j % (dw + 1) == 0) ? 1 : 0,
                   (dir < 0 && j % (dw + 1) == 0) ? 1 : 0, 1, 0, 0);
        end else if (j == ne) begin
          chk_outs(tag, t, 0, 0, 0, 1, 0);
        end else begin
          chk_outs(tag, t, 0, 0, 0, 0, 1);
          fin = 1'b1;
        end
      end
      j++;
    end
    bus.abort = 1'b0;
    if (!fin) chk({tag, ".timeout"}, 32'd0, 32'd1);
    if (d == 0 || ja < 0 || ja >= ne) model_level = t;
  endtask

  initial begin
    int b_lvl[6] = '{0, 1, 1, 1, 0, 0};
    int b_su[6]  = '{1, 0, 0, 0, 0, 0};
    int b_sd[6]  = '{0, 0, 0, 1, 0, 0};
    int b_bz[6]  = '{1, 0, 0, 1, 0, 0};
    int b_dn[6]  = '{0, 1, 0, 0, 1, 0};
    int b_rd[6]  = '{0, 0, 1, 0, 0, 1};
    int t, dw, d, ne, ja;

    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_level = '0;
    bus.req_dwell = '0;
    bus.abort     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outs("reset", 0, 0, 0, 0, 0, 1);
    reset_n = 1'b1;

    run_req("ramp_up", 3, 2, -1);
    run_req("ramp_dn", 0, 0, -1);
    run_req("to2", 2, 1, -1);
    run_req("zero_dist", 2, 3, -1);
    run_req("to0", 0, 0, -1);
    run_req("abort", 3, 0, 1);
    chk("abort.model_level", 32'(bus.level), 32'd1);
    run_req("after_abort", 0, 1, -1);

    // Held req_valid: second target only taken once back in IDLE.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_level = LW'(1);
    bus.req_dwell = '0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) bus.req_level = LW'(0);
      @(negedge clk);
      chk_outs("b2b", b_lvl[j], b_su[j], b_sd[j], b_bz[j], b_dn[j], b_rd[j]);
      chk("b2b.ready_busy", 32'(bus.req_ready && bus.busy), 32'd0);
      if (j == 5) bus.req_valid = 1'b0;
    end
    model_level = 0;

    // Async reset dropped mid-DWELL, away from any clock edge.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_level = LW'(3);
    bus.req_dwell = DW'(3);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("arst.pre_busy", 32'(bus.busy), 32'd1);
    chk("arst.pre_level", 32'(bus.level), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_outs("arst", 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    reset_n = 1'b1;
    model_level = 0;

    for (int i = 0; i < 40; i++) begin
      t  = $urandom_range(0, 3);
      dw = $urandom_range(0, 4);
      d  = (t > model_level) ? t - model_level : model_level - t;
      ne = (d == 0) ? 0 : 1 + (d - 1) * (dw + 1);
      ja = -1;
      if (d > 0 && $urandom_range(0, 3) == 0) ja = $urandom_range(0, ne - 1);
      run_req("rand", t, dw, ja);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
